serial_word_receiver: RTL and testbench



---
 rtl/rx_pkg.sv | 14 +
 rtl/rx_shift_reg.sv | 30 +++
 rtl/serial_word_receiver.sv | 134 +++++++++++++
 tb/tb_serial_word_receiver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and sizing helpers for the serial word receiver.
package rx_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/rx_shift_reg.sv
// Direction-selectable deserialising shift register with synchronous clear.
module rx_shift_reg
    import rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             msb_first,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);
    // q_next is exported so the top can capture the word on its final data bit.
    always_comb begin
        q_next = msb_first ? {q[WIDTH-2:0], sin} : {sin, q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= q_next;
        end
    end
endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: frame FSM, bit counter, optional even parity
// and a one-entry valid/ready output buffer.
module serial_word_receiver
    import rx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             msb_first,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             dir, dir_nx;
    logic             sr_clear, sr_en;
    logic [WIDTH-1:0] sr, sr_shifted;
    logic             done;
    logic [WIDTH-1:0] done_word;
    logic             done_perr;
    logic             done_p0;
    logic [WIDTH-1:0] done_word_p0;
    logic             done_perr_p0;

    rx_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (sr_clear),
        .enable    (sr_en),
        .msb_first (dir),
        .sin       (sin),
        .q         (sr),
        .q_next    (sr_shifted)
    );

    // start has priority over everything, including a completing bit.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        dir_nx    = dir;
        sr_clear  = 1'b0;
        sr_en     = 1'b0;
        done      = 1'b0;
        done_word = sr;
        done_perr = 1'b0;
        if (start) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
            dir_nx   = msb_first;
            sr_clear = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (sin_valid) begin
                        sr_en  = 1'b1;
                        cnt_nx = cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            if (PARITY_EN) begin
                                state_nx = PARITY;
                            end else begin
                                state_nx  = IDLE;
                                done      = 1'b1;
                                done_word = sr_shifted;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (sin_valid) begin
                        state_nx  = IDLE;
                        done      = 1'b1;
                        done_perr = (^sr) ^ sin;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p0: frame control plus the completed word awaiting the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            dir          <= 1'b0;
            done_p0      <= 1'b0;
            done_word_p0 <= '0;
            done_perr_p0 <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            dir          <= dir_nx;
            done_p0      <= done;
            done_word_p0 <= done_word;
            done_perr_p0 <= done_perr;
        end
    end

    // Output buffer: a full, unaccepted buffer drops the new word and flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_p0) begin
                if (!word_valid || word_ready) begin
                    word_out   <= done_word_p0;
                    parity_err <= done_perr_p0;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4, PARITY_EN=1) with an expected-word queue.
module tb_serial_word_receiver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       msb_first;
    logic       sin;
    logic       sin_valid;
    logic [3:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    typedef struct packed {
        logic [3:0] w;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    serial_word_receiver #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msb_first  (msb_first),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bits[3] is sent first; LSB-first order reverses the word.
    function automatic exp_t model(input logic msb, input logic [3:0] bits, input logic par);
        exp_t e;
        for (int i = 0; i < 4; i++) e.w[i] = msb ? bits[i] : bits[3 - i];
        e.p = (^bits) ^ par;
        return e;
    endfunction

    task automatic bit_in(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    task automatic send_frame(input logic msb, input logic [3:0] bits, input logic par, input int gap);
        start     = 1'b1;
        msb_first = msb;
        sin_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                sin = ~sin;
                tick();
                chk("busy_gap", busy, 1);
            end
            bit_in(i == 0 ? par : bits[i - 1]);
        end
    endtask

    task automatic check_load(input string tag);
        exp_t e;
        chk({tag, "_valid"}, word_valid, 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_word"}, word_out, e.w);
            chk({tag, "_perr"}, parity_err, e.p);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        msb_first  = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        word_ready = 1'b1;
        #1;
        chk("rst_word", word_out, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: MSB first 1011, parity 1
        sb.push_back(model(1'b1, 4'b1011, 1'b1));
        send_frame(1'b1, 4'b1011, 1'b1, 0);
        chk("t1_busy_low", busy, 0);
        chk("t1_not_yet", word_valid, 0);
        tick();
        check_load("t1");
        chk("t1_word_lit", word_out, 4'b1011);
        tick();
        chk("t1_drained", word_valid, 0);

        // 2: LSB first 1,0,1,1, parity 0
        sb.push_back(model(1'b0, 4'b1011, 1'b0));
        send_frame(1'b0, 4'b1011, 1'b0, 0);
        tick();
        check_load("t2");
        chk("t2_word_lit", word_out, 4'b1101);
        chk("t2_perr_lit", parity_err, 1);
        tick();

        // 3: idle gaps with sin toggling
        sb.push_back(model(1'b1, 4'b1011, 1'b1));
        send_frame(1'b1, 4'b1011, 1'b1, 3);
        chk("t3_busy_low", busy, 0);
        tick();
        check_load("t3");
        tick();

        // 4: backpressure, overrun, then accept-and-reload in the same cycle
        word_ready = 1'b0;
        sb.push_back(model(1'b1, 4'b1011, 1'b1));
        send_frame(1'b1, 4'b1011, 1'b1, 0);
        tick();
        check_load("t4a");
        send_frame(1'b1, 4'b0110, 1'b0, 0);
        chk("t4_ovr_early", overrun, 0);
        tick();
        chk("t4_ovr_pulse", overrun, 1);
        chk("t4_word_hold", word_out, 4'b1011);
        chk("t4_valid_hold", word_valid, 1);
        tick();
        chk("t4_ovr_clear", overrun, 0);
        chk("t4_word_hold2", word_out, 4'b1011);
        sb.push_back(model(1'b1, 4'b0110, 1'b0));
        send_frame(1'b1, 4'b0110, 1'b0, 0);
        word_ready = 1'b1;
        tick();
        check_load("t4b");
        chk("t4b_ovr", overrun, 0);
        chk("t4b_word_lit", word_out, 4'b0110);
        tick();
        chk("t4_drained", word_valid, 0);

        // 5: restart mid-frame, only the second frame completes
        start     = 1'b1;
        msb_first = 1'b1;
        tick();
        start = 1'b0;
        bit_in(1'b1);
        bit_in(1'b1);
        sb.push_back(model(1'b1, 4'b0001, 1'b1));
        send_frame(1'b1, 4'b0001, 1'b1, 0);
        chk("t5_no_early", word_valid, 0);
        tick();
        check_load("t5");
        tick();
        chk("t5_single", word_valid, 0);

        // start colliding with the parity bit aborts the frame
        start     = 1'b1;
        msb_first = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        start     = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        tick();
        start     = 1'b0;
        sin_valid = 1'b0;
        chk("tc_busy", busy, 1);
        tick();
        chk("tc_no_word", word_valid, 0);
        chk("tc_no_ovr", overrun, 0);

        // 6: async reset mid-frame with a word pending
        word_ready = 1'b0;
        sb.push_back(model(1'b1, 4'b1011, 1'b1));
        send_frame(1'b1, 4'b1011, 1'b1, 0);
        tick();
        check_load("t6a");
        start = 1'b1;
        tick();
        start = 1'b0;
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_word", word_out, 0);
        chk("t6_valid", word_valid, 0);
        chk("t6_perr", parity_err, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovr", overrun, 0);
        tick();
        rst_n = 1'b1;
        word_ready = 1'b1;
        bit_in(1'b1);
        bit_in(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_never_valid", word_valid, 0);
            chk("t6_idle", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
